// File: rtl/twiddle_addr_gen_pkg.sv
// Shared definitions for the R2SDF FFT stage control logic: FSM encoding,
// constant-evaluable helpers and default geometry.
package twiddle_addr_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int DEF_NLOG2 = 7;
  localparam int DEF_STAGE = 0;
  localparam int DEF_ADDRW = 6;

  // Ceiling log2; returns 0 for values of 0 or 1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

  function automatic int fft_len(input int nlog2);
    return 1 << nlog2;
  endfunction

  // Delay-line depth of a DIF stage: N >> (stage+1).
  function automatic int stage_delay(input int nlog2, input int stage);
    return (1 << nlog2) >> (stage + 1);
  endfunction

endpackage

// File: rtl/twiddle_addr_gen.sv
// Frame counter, butterfly select and twiddle-ROM address generator for one
// radix-2 SDF (DIF) stage, with strobes aligned to the ROM's 1-cycle read.
module twiddle_addr_gen
  import twiddle_addr_gen_pkg::*;
#(
  parameter int NLOG2 = DEF_NLOG2,
  parameter int STAGE = DEF_STAGE,
  parameter int ADDRW = DEF_ADDRW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_sop,
  output logic             in_ready,
  output logic [ADDRW-1:0] addr_re,
  output logic [ADDRW-1:0] addr_im,
  output logic             bf_sel,
  output logic             ctrl_valid,
  output logic             flush,
  output logic             tw_valid,
  output logic             tw_sop,
  output logic             sync_err
);

  localparam int N    = fft_len(NLOG2);
  localparam int D    = stage_delay(NLOG2, STAGE);
  localparam int DW   = (D > 1) ? clog2(D) : 1;
  localparam int PBIT = NLOG2 - 1 - STAGE;

  if (ADDRW != NLOG2 - 1) begin : g_bad_addrw
    $error("twiddle_addr_gen: ADDRW must equal NLOG2-1");
  end
  if (STAGE < 0 || STAGE >= NLOG2) begin : g_bad_stage
    $error("twiddle_addr_gen: STAGE out of range 0..NLOG2-1");
  end

  state_e             state_q, state_d;
  logic [NLOG2-1:0]   c_q, c_d;
  logic [DW-1:0]      dcnt_q, dcnt_d;
  logic [ADDRW-1:0]   addr_q, addr_d;
  logic               bf_sel_q, bf_sel_d;
  logic               ctrl_valid_q, ctrl_valid_d;
  logic               flush_q, flush_d;
  logic               sync_err_q, sync_err_d;
  logic               sop_q, sop_d;
  logic               tw_valid_q;
  logic               tw_sop_q;

  logic               take_slot;
  logic               flush_slot;
  logic [NLOG2-1:0]   c_eff;

  // Drain slot d>0 is the only time the stage refuses input.
  assign in_ready = (state_q != ST_DRAIN) || (dcnt_q == '0);

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    c_d          = c_q;
    dcnt_d       = dcnt_q;
    addr_d       = addr_q;
    bf_sel_d     = bf_sel_q;
    ctrl_valid_d = 1'b0;
    flush_d      = 1'b0;
    sync_err_d   = 1'b0;
    sop_d        = 1'b0;
    take_slot    = 1'b0;
    flush_slot   = 1'b0;
    c_eff        = c_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid && in_sop) begin
          take_slot = 1'b1;
          c_eff     = '0;
          state_d   = ST_RUN;
        end else if (in_valid) begin
          sync_err_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (in_valid) begin
          take_slot = 1'b1;
          if (in_sop) begin
            c_eff      = '0;
            sync_err_d = (c_q != '0);
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == '0 && in_valid && in_sop) begin
          // Back-to-back frame: the new frame's fill slots drain the old one.
          take_slot = 1'b1;
          c_eff     = '0;
          state_d   = ST_RUN;
        end else begin
          flush_slot = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (take_slot) begin
      ctrl_valid_d = 1'b1;
      bf_sel_d     = c_eff[PBIT];
      addr_d       = c_eff[PBIT] ? '0 : ADDRW'((int'(c_eff) & (D - 1)) << STAGE);
      sop_d        = (c_eff == '0);
      c_d          = c_eff + NLOG2'(1);
      if (c_eff == NLOG2'(N - 1)) begin
        state_d = ST_DRAIN;
        dcnt_d  = '0;
      end
    end

    if (flush_slot) begin
      ctrl_valid_d = 1'b1;
      flush_d      = 1'b1;
      bf_sel_d     = 1'b0;
      addr_d       = ADDRW'(int'(dcnt_q) << STAGE);
      if (dcnt_q == DW'(D - 1)) begin
        state_d = ST_IDLE;
        dcnt_d  = '0;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

  // NOTE: non-blocking assignments keep every register sampling the
  // pre-edge value, so the strobe pipe shifts by exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      c_q          <= '0;
      dcnt_q       <= '0;
      addr_q       <= '0;
      bf_sel_q     <= 1'b0;
      ctrl_valid_q <= 1'b0;
      flush_q      <= 1'b0;
      sync_err_q   <= 1'b0;
      sop_q        <= 1'b0;
      tw_valid_q   <= 1'b0;
      tw_sop_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      c_q          <= c_d;
      dcnt_q       <= dcnt_d;
      addr_q       <= addr_d;
      bf_sel_q     <= bf_sel_d;
      ctrl_valid_q <= ctrl_valid_d;
      flush_q      <= flush_d;
      sync_err_q   <= sync_err_d;
      sop_q        <= sop_d;
      // ROM word is valid one cycle after its address was presented.
      tw_valid_q   <= ctrl_valid_q;
      tw_sop_q     <= sop_q;
    end
  end

  assign addr_re    = addr_q;
  assign addr_im    = addr_q;
  assign bf_sel     = bf_sel_q;
  assign ctrl_valid = ctrl_valid_q;
  assign flush      = flush_q;
  assign sync_err   = sync_err_q;
  assign tw_valid   = tw_valid_q;
  assign tw_sop     = tw_sop_q;

endmodule

// File: tb/tb_twiddle_addr_gen.sv
// Directed bench for twiddle_addr_gen with N=16, STAGE=1 (D=4, ADDRW=3).
module tb_twiddle_addr_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sop;
  logic       in_ready;
  logic [2:0] addr_re;
  logic [2:0] addr_im;
  logic       bf_sel;
  logic       ctrl_valid;
  logic       flush;
  logic       tw_valid;
  logic       tw_sop;
  logic       sync_err;

  int n_pass  = 0;
  int n_check = 0;

  always #5 clk = ~clk;

  twiddle_addr_gen #(
    .NLOG2(4),
    .STAGE(1),
    .ADDRW(3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sop    (in_sop),
    .in_ready  (in_ready),
    .addr_re   (addr_re),
    .addr_im   (addr_im),
    .bf_sel    (bf_sel),
    .ctrl_valid(ctrl_valid),
    .flush     (flush),
    .tw_valid  (tw_valid),
    .tw_sop    (tw_sop),
    .sync_err  (sync_err)
  );

  typedef struct {
    logic       v;
    logic       sop;
    logic       cv;
    logic       fl;
    logic [2:0] addr;
    logic       bf;
    logic       se;
    logic       s0;
    logic       rdy;
  } vec_t;

  vec_t vecs[$];

  // Hand-computed slot pattern for one 16-sample frame at STAGE=1.
  int fr_addr[16] = '{0, 2, 4, 6, 0, 0, 0, 0, 0, 2, 4, 6, 0, 0, 0, 0};
  int fr_bf[16]   = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};

  task automatic check(input string name, input int idx, input logic [31:0] got,
                       input logic [31:0] exp);
    n_check++;
    if (got === exp) n_pass++;
    else $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
  endtask

  task automatic add(input logic v, input logic sop, input logic cv, input logic fl,
                     input int addr, input logic bf, input logic se, input logic s0,
                     input logic rdy);
    vec_t t;
    t.v    = v;
    t.sop  = sop;
    t.cv   = cv;
    t.fl   = fl;
    t.addr = 3'(addr);
    t.bf   = bf;
    t.se   = se;
    t.s0   = s0;
    t.rdy  = rdy;
    vecs.push_back(t);
  endtask

  task automatic add_frame(input logic first_sop);
    for (int c = 0; c < 16; c++)
      add(1'b1, (c == 0) && first_sop, 1'b1, 1'b0, fr_addr[c], fr_bf[c][0], 1'b0,
          c == 0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pack_outs();
    return 32'({ctrl_valid, flush, addr_re, addr_im, bf_sel, sync_err, in_ready});
  endfunction

  initial begin
    logic prev_cv;
    logic prev_s0;
    logic [31:0] exp;

    // Frame after reset, then four drain slots and IDLE.
    add_frame(1'b1);
    add(0, 0, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 1, 1, 2, 0, 0, 0, 0);
    add(0, 0, 1, 1, 4, 0, 0, 0, 0);
    add(0, 0, 1, 1, 6, 0, 0, 0, 1);
    add(0, 0, 0, 0, 6, 0, 0, 0, 1);
    // Unframed samples in IDLE are dropped and flagged; state stays IDLE.
    add(1, 0, 0, 0, 6, 0, 1, 0, 1);
    add(1, 0, 0, 0, 6, 0, 1, 0, 1);
    add(0, 0, 0, 0, 6, 0, 0, 0, 1);
    // Two back-to-back frames: no flush slots between them.
    add_frame(1'b1);
    add_frame(1'b1);
    // Third frame with gaps, then a resync at c=6.
    add(1, 1, 1, 0, 0, 0, 0, 1, 1);
    add(1, 0, 1, 0, 2, 0, 0, 0, 1);
    add(1, 0, 1, 0, 4, 0, 0, 0, 1);
    add(1, 0, 1, 0, 6, 0, 0, 0, 1);
    add(0, 0, 0, 0, 6, 0, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 0, 0, 1);
    add(0, 0, 0, 0, 0, 1, 0, 0, 1);
    add(1, 0, 1, 0, 0, 1, 0, 0, 1);
    add(1, 1, 1, 0, 0, 0, 1, 1, 1);
    add(1, 0, 1, 0, 2, 0, 0, 0, 1);
    add(1, 0, 1, 0, 4, 0, 0, 0, 1);

    // Reset state.
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sop   = 1'b0;
    tick();
    tick();
    check("reset_outs", 0, 32'({pack_outs(), tw_valid, tw_sop}), 32'({11'b00000000001, 2'b00}));
    rst = 1'b0;
    tick();
    check("post_reset_idle", 0, 32'({pack_outs(), tw_valid, tw_sop}), 32'({11'b00000000001, 2'b00}));

    prev_cv = 1'b0;
    prev_s0 = 1'b0;
    foreach (vecs[i]) begin
      in_valid = vecs[i].v;
      in_sop   = vecs[i].sop;
      tick();
      exp = 32'({vecs[i].cv, vecs[i].fl, vecs[i].addr, vecs[i].addr, vecs[i].bf,
                 vecs[i].se, vecs[i].rdy});
      check("vec", i, pack_outs(), exp);
      check("tw", i, 32'({tw_valid, tw_sop}), 32'({prev_cv, prev_s0}));
      prev_cv = vecs[i].cv;
      prev_s0 = vecs[i].s0;
    end

    // Reset asserted while sample c=9 is accepted.
    in_valid = 1'b0;
    in_sop   = 1'b0;
    rst      = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1'b1;
      in_sop   = (c == 0);
      tick();
    end
    check("c8_slot", 0, 32'({ctrl_valid, addr_re, bf_sel}), 32'({1'b1, 3'd0, 1'b0}));
    in_sop = 1'b0;
    rst    = 1'b1;
    tick();
    check("rst_mid_frame", 0, 32'({pack_outs(), tw_valid, tw_sop}), 32'({11'b00000000001, 2'b00}));
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    check("rst_no_tw_1", 0, 32'({ctrl_valid, tw_valid, tw_sop, in_ready}), 32'(4'b0001));
    tick();
    check("rst_no_tw_2", 0, 32'({ctrl_valid, tw_valid, tw_sop}), 32'(3'b000));
    // Frame was abandoned: an unframed sample now lands in IDLE.
    in_valid = 1'b1;
    tick();
    check("rst_back_idle", 0, 32'({sync_err, ctrl_valid}), 32'(2'b10));
    in_valid = 1'b0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
